// File: rtl/sync_gen_if.sv
// rtl/sync_gen_if.sv - control/status bundle between a sync_gen and its host
// master drives enable, arm and sync sources; slave is the generator.
interface sync_gen_if #(
  parameter int CNT_BITS = 32
);
  logic                ce;
  logic                arm;
  logic                ext_sync;
  logic                sw_sync;
  logic                sync_out;
  logic                armed;
  logic                running;
  logic [CNT_BITS-1:0] sync_cnt;
  logic                err;

  modport master (
    output ce, arm, ext_sync, sw_sync,
    input  sync_out, armed, running, sync_cnt, err
  );

  modport slave (
    input  ce, arm, ext_sync, sw_sync,
    output sync_out, armed, running, sync_cnt, err
  );
endinterface

// File: rtl/sync_gen.sv
// rtl/sync_gen.sv - armable periodic sync-pulse generator feeding the sync delay stage
// Optional misalignment checker enabled by defining SYNC_GEN_CHECK_EN.
module sync_gen #(
  parameter int PERIOD   = 1024,
  parameter int CNT_BITS = 32
) (
  input logic       clk,
  input logic       rst_n,
  sync_gen_if.slave bus
);

  localparam int               CTR_W    = $clog2(PERIOD);
  localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUNNING
  } state_t;

  state_t              state_q, state_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;
  logic                ext_q;
  logic                sync_q, sync_d;
  logic                armed_q, armed_d;
  logic                running_q, running_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                ext_edge;
  logic                align;
  logic                emit;

  assign ext_edge = bus.ext_sync & ~ext_q;
  assign align    = bus.ce & (ext_edge | bus.sw_sync);

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    emit    = 1'b0;
    if (bus.ce) begin
      case (state_q)
        S_IDLE: begin
          if (bus.arm) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (!bus.arm && align) begin
            state_d = S_RUNNING;
            emit    = 1'b1;
            ctr_d   = CTR_LOAD;
          end
        end
        S_RUNNING: begin
          // Re-arm wins over a due pulse so the next pulse is always freshly aligned
          if (bus.arm) begin
            state_d = S_ARMED;
          end else if (ctr_q == '0) begin
            emit  = 1'b1;
            ctr_d = CTR_LOAD;
          end else begin
            ctr_d = ctr_q - CTR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    sync_d    = emit;
    cnt_d     = cnt_q + CNT_BITS'(emit);
    armed_d   = (state_d == S_ARMED);
    running_d = (state_d == S_RUNNING);
  end

  // ext_q resets high so a level already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      ext_q     <= 1'b1;
      sync_q    <= 1'b0;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      ext_q     <= bus.ext_sync;
      sync_q    <= sync_d;
      armed_q   <= armed_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.sync_out = sync_q;
  assign bus.armed    = armed_q;
  assign bus.running  = running_q;
  assign bus.sync_cnt = cnt_q;

`ifdef SYNC_GEN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.ce && bus.arm) begin
      err_d = 1'b0;
    end else if (state_q == S_RUNNING && align && ctr_q != '0) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
